// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS field positions and the serialiser state encoding.
package uart_pkg;

    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous FIFO with a registered read port: the head is loaded into o_rdata
// on the pop edge and held there until the next pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_rdata;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_rdata;
    // Full is judged before any same-cycle pop, so a push into a full FIFO is lost.
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_rdata  <= r_mem[r_rd_ptr];
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, overflow flag, serialiser FSM
// with a single shared baud counter, and the registered serial output.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        uart_tx,
    output logic        irq_empty
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    uart_tx_state_e r_state;
    logic [BW-1:0]  r_baud;
    logic [2:0]     r_bit_idx;
    logic           r_tx;
    logic           r_ovf;
    logic [31:0]    r_rdata;

    logic           w_push;
    logic           w_pop;
    logic           w_rd;
    logic           w_status_rd;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic [7:0]     w_head;
    logic [31:0]    w_status;
    logic           w_busy;
    logic           w_unused;

    assign w_push      = bus_sel & bus_we & (bus_addr[3:2] == UART_TXDATA[3:2]);
    assign w_rd        = bus_sel & ~bus_we;
    assign w_status_rd = w_rd & (bus_addr[3:2] == UART_STATUS[3:2]);
    assign w_pop       = (r_state == IDLE) & ~w_empty;
    assign w_busy      = (r_state != IDLE);
    assign w_unused    = ^{bus_addr[1:0], bus_wdata[31:8]};

    assign bus_rdata = r_rdata;
    assign uart_tx   = r_tx;
    assign irq_empty = w_empty & ~w_busy;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (bus_wdata[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // STATUS word assembled from live flags.
    always_comb begin
        w_status                            = 32'd0;
        w_status[STAT_COUNT_LSB +: CW]      = w_count;
        w_status[STAT_OVF]                  = r_ovf;
        w_status[STAT_BUSY]                 = w_busy;
        w_status[STAT_EMPTY]                = w_empty;
        w_status[STAT_FULL]                 = w_full;
    end

    // Read capture and sticky overflow; a STATUS read returns the pre-clear flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_rd) begin
                r_rdata <= w_status_rd ? w_status : 32'd0;
            end
            if (w_push & w_full) begin
                r_ovf <= 1'b1;
            end else if (w_status_rd) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Serialiser: the FIFO's registered head doubles as the shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_baud    <= '0;
                    r_bit_idx <= 3'd0;
                    r_tx      <= w_empty;
                    if (!w_empty) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud    <= '0;
                        r_bit_idx <= 3'd0;
                        r_tx      <= w_head[0];
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= w_head[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                default: begin
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: expected bytes and read data are queued at
// stimulus time and popped by independent serial-line and read-data monitors.
module tb_uart_tx_mmio;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_sel = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_addr = 4'h0;
    logic [31:0] bus_wdata = 32'd0;
    logic [31:0] bus_rdata;
    logic        uart_tx;
    logic        irq_empty;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0]  tx_q[$];
    logic [31:0] rd_q[$];
    logic [3:0]  rd_a[$];
    int          start_cyc[$];

    uart_tx_mmio #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_sel   (bus_sel),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .uart_tx   (uart_tx),
        .irq_empty (irq_empty)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    task automatic bus_cycle(input logic sel, input logic we, input logic [3:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus_sel   = sel;
        bus_we    = we;
        bus_addr  = a;
        bus_wdata = d;
    endtask

    task automatic bus_idle();
        bus_cycle(1'b0, 1'b0, 4'h0, 32'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input bit accept);
        bus_cycle(1'b1, 1'b1, a, d);
        if (accept) tx_q.push_back(d[7:0]);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        bus_cycle(1'b1, 1'b0, a, 32'd0);
        rd_q.push_back(exp);
        rd_a.push_back(a);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!irq_empty && n < bound);
        check("drain_timeout", {31'd0, irq_empty}, 32'd1);
    endtask

    task automatic count_lows(input string name, input int ncyc);
        int lows;
        lows = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check(name, lows, 32'd0);
    endtask

    // Serial-line monitor: decodes each frame, checks every sample plus the idle cycle.
    initial begin
        logic       active;
        logic [7:0] exp_b;
        logic [7:0] dec;
        logic       expbit;
        int         cnt;
        int         mism;
        bit         unexp;
        active = 1'b0;
        cnt = 0;
        mism = 0;
        unexp = 1'b0;
        exp_b = 8'h00;
        dec = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                active = 1'b0;
            end else if (!active && uart_tx === 1'b0) begin
                active = 1'b1;
                cnt = 0;
                mism = 0;
                dec = 8'h00;
                start_cyc.push_back(cyc);
                if (tx_q.size() == 0) begin
                    unexp = 1'b1;
                    exp_b = 8'h00;
                end else begin
                    unexp = 1'b0;
                    exp_b = tx_q.pop_front();
                end
            end
            if (active && rst_n) begin
                if (cnt < CPB) expbit = 1'b0;
                else if (cnt < 9 * CPB) expbit = exp_b[(cnt - CPB) / CPB];
                else expbit = 1'b1;
                if (uart_tx !== expbit) mism++;
                if (cnt >= CPB && cnt < 9 * CPB && (cnt % CPB) == CPB / 2)
                    dec[(cnt - CPB) / CPB] = uart_tx;
                if (cnt == FRAME) begin
                    checks++;
                    if (unexp || mism != 0 || dec !== exp_b) begin
                        errors++;
                        $display("FAIL frame: got 0x%02h expected 0x%02h bad_samples=%0d unexpected=%0d",
                                 dec, exp_b, mism, unexp);
                    end
                    active = 1'b0;
                end
                cnt++;
            end
        end
    end

    // Read-data monitor: a read seen at a rising edge is compared at the next falling edge.
    initial begin
        bit          seen;
        logic [31:0] e;
        logic [3:0]  a;
        forever begin
            @(posedge clk);
            seen = rst_n && bus_sel && !bus_we;
            @(negedge clk);
            if (seen) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rdata: got 0x%08h with no read expected", bus_rdata);
                end else begin
                    e = rd_q.pop_front();
                    a = rd_a.pop_front();
                    check($sformatf("rdata@0x%0h", a), bus_rdata, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_irq", {31'd0, irq_empty}, 32'd1);
        check("rst_rdata", bus_rdata, 32'd0);
        rst_n = 1'b1;
        rd(4'h4, 32'h0000_0002);
        bus_idle();

        // Single byte: latency, frame shape, irq timing
        wr(4'h0, 32'h0000_0055, 1'b1);
        bus_idle();
        @(negedge clk);
        check("lat_tx_still_high", {31'd0, uart_tx}, 32'd1);
        check("irq_after_push", {31'd0, irq_empty}, 32'd0);
        @(negedge clk);
        check("lat_tx_fall", {31'd0, uart_tx}, 32'd0);
        repeat (39) @(negedge clk);
        check("irq_stop_bit", {31'd0, irq_empty}, 32'd0);
        @(negedge clk);
        check("irq_after_frame", {31'd0, irq_empty}, 32'd1);
        rd(4'h4, 32'h0000_0002);
        bus_idle();

        // Burst of six: one popped, four queued, last dropped
        for (int i = 1; i <= 6; i++) wr(4'h0, i, (i <= 5));
        rd(4'h4, 32'h0000_040D);
        rd(4'h4, 32'h0000_0405);
        bus_idle();
        wait_idle(600);
        check("burst_all_sent", tx_q.size(), 32'd0);

        // Back-to-back frames with a single idle cycle between them
        wr(4'h0, 32'h0000_0048, 1'b1);
        wr(4'h0, 32'h0000_0069, 1'b1);
        bus_idle();
        wait_idle(300);
        check("b2b_start_gap", start_cyc[start_cyc.size()-1] - start_cyc[start_cyc.size()-2], FRAME + 1);

        // Reset during data bit 3
        wr(4'h0, 32'h0000_00A5, 1'b1);
        bus_idle();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (uart_tx === 1'b1 && n < 10);
        check("t5_start", {31'd0, uart_tx}, 32'd0);
        repeat (17) @(negedge clk);
        check("bit3_level", {31'd0, uart_tx}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_async_irq", {31'd0, irq_empty}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_lows("no_resume", 60);
        rd(4'h4, 32'h0000_0002);

        // Unmapped reads return zero; writes off TXDATA are ignored
        rd(4'h0, 32'd0);
        rd(4'h8, 32'd0);
        rd(4'hC, 32'd0);
        wr(4'h4, 32'hFFFF_FFFF, 1'b0);
        wr(4'h8, 32'h0000_0012, 1'b0);
        wr(4'hC, 32'h0000_0034, 1'b0);
        rd(4'h4, 32'h0000_0002);
        bus_idle();
        count_lows("no_spurious_frame", 60);

        repeat (3) @(negedge clk);
        check("reads_drained", rd_q.size(), 32'd0);
        check("bytes_drained", tx_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
